// File: rtl/max_tree_pkg.sv
// Shared definitions for the max/min reduction tree: search-mode encodings
// and elaboration-time helpers for index width, tree depth and level sizes.
package max_tree_pkg;

    localparam int MT_MAX = 0;
    localparam int MT_MIN = 1;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int tree_depth(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    // Entries present at level l: repeated ceil-halving equals ceil(n / 2^l)
    function automatic int lvl_cnt(input int n, input int l);
        return (n + (1 << l) - 1) >> l;
    endfunction

endpackage

// File: rtl/max_tree_node.sv
// Combinational compare-select of one value/index pair. Operand a is the
// lower-index (or earlier) candidate and is kept unless b is strictly better.
module max_tree_node
    import max_tree_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int SIGNED = 0,
    parameter int MODE   = MT_MAX,
    parameter int IW     = 1
) (
    input  logic [WIDTH-1:0] i_a_val,
    input  logic [IW-1:0]    i_a_idx,
    input  logic [WIDTH-1:0] i_b_val,
    input  logic [IW-1:0]    i_b_idx,
    output logic [WIDTH-1:0] o_val,
    output logic [IW-1:0]    o_idx
);

    logic w_b_gt;
    logic w_b_lt;
    logic w_take_b;

    always_comb begin
        if (SIGNED != 0) begin
            w_b_gt = $signed(i_b_val) > $signed(i_a_val);
            w_b_lt = $signed(i_b_val) < $signed(i_a_val);
        end else begin
            w_b_gt = i_b_val > i_a_val;
            w_b_lt = i_b_val < i_a_val;
        end
        w_take_b = (MODE == MT_MIN) ? w_b_lt : w_b_gt;
        o_val    = w_take_b ? i_b_val : i_a_val;
        o_idx    = w_take_b ? i_b_idx : i_a_idx;
    end

endmodule

// File: rtl/max_tree_pipe.sv
// Pipelined max/min search over N_CH channels with a register after every
// tree level, plus an optional per-frame peak-hold stage with position count.
module max_tree_pipe
    import max_tree_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int N_CH    = 8,
    parameter int SIGNED  = 0,
    parameter int MODE    = MT_MAX,
    parameter int HOLD_EN = 0,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic                    last,
    input  logic [WIDTH*N_CH-1:0]   data_in,
    output logic [WIDTH-1:0]        data_out,
    output logic [idx_w(N_CH)-1:0]  idx_out,
    output logic [CNT_W-1:0]        pos_out,
    output logic                    valid_out
);

    localparam int IW = idx_w(N_CH);
    localparam int D  = tree_depth(N_CH);

    logic [N_CH-1:0][WIDTH-1:0] w_ch_val;
    logic [N_CH-1:0][IW-1:0]    w_ch_idx;
    logic                       w_in_last;

    assign w_in_last = we & last;

    genvar gi, gj;
    generate
        // Channel 0 sits in the most significant slice of data_in
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign w_ch_val[gi] = data_in[(N_CH-1-gi)*WIDTH +: WIDTH];
            assign w_ch_idx[gi] = IW'(gi);
        end

        for (gi = 0; gi < D; gi++) begin : g_lvl
            localparam int NI = lvl_cnt(N_CH, gi);
            localparam int NO = lvl_cnt(N_CH, gi + 1);

            logic [NI-1:0][WIDTH-1:0] w_src_val;
            logic [NI-1:0][IW-1:0]    w_src_idx;
            logic                     w_src_vld;
            logic                     w_src_last;
            logic [NO-1:0][WIDTH-1:0] w_sel_val;
            logic [NO-1:0][IW-1:0]    w_sel_idx;
            logic [NO-1:0][WIDTH-1:0] r_val;
            logic [NO-1:0][IW-1:0]    r_idx;
            logic                     r_vld;
            logic                     r_last;

            if (gi == 0) begin : g_src
                assign w_src_val  = w_ch_val;
                assign w_src_idx  = w_ch_idx;
                assign w_src_vld  = we;
                assign w_src_last = w_in_last;
            end else begin : g_src
                assign w_src_val  = g_lvl[gi-1].r_val;
                assign w_src_idx  = g_lvl[gi-1].r_idx;
                assign w_src_vld  = g_lvl[gi-1].r_vld;
                assign w_src_last = g_lvl[gi-1].r_last;
            end

            for (gj = 0; gj < NO; gj++) begin : g_node
                if (2*gj + 1 < NI) begin : g_pair
                    max_tree_node #(
                        .WIDTH  (WIDTH),
                        .SIGNED (SIGNED),
                        .MODE   (MODE),
                        .IW     (IW)
                    ) u_node (
                        .i_a_val (w_src_val[2*gj]),
                        .i_a_idx (w_src_idx[2*gj]),
                        .i_b_val (w_src_val[2*gj+1]),
                        .i_b_idx (w_src_idx[2*gj+1]),
                        .o_val   (w_sel_val[gj]),
                        .o_idx   (w_sel_idx[gj])
                    );
                end else begin : g_pass
                    // Unpaired highest entry rides through to the next level
                    assign w_sel_val[gj] = w_src_val[2*gj];
                    assign w_sel_idx[gj] = w_src_idx[2*gj];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_val  <= '0;
                    r_idx  <= '0;
                    r_vld  <= 1'b0;
                    r_last <= 1'b0;
                end else begin
                    r_val  <= w_sel_val;
                    r_idx  <= w_sel_idx;
                    r_vld  <= w_src_vld;
                    r_last <= w_src_last;
                end
            end
        end
    endgenerate

    logic [WIDTH-1:0] w_res_val;
    logic [IW-1:0]    w_res_idx;
    logic             w_res_vld;
    logic             w_res_last;

    generate
        if (D == 0) begin : g_res
            assign w_res_val  = w_ch_val[0];
            assign w_res_idx  = w_ch_idx[0];
            assign w_res_vld  = we;
            assign w_res_last = w_in_last;
        end else begin : g_res
            assign w_res_val  = g_lvl[D-1].r_val[0];
            assign w_res_idx  = g_lvl[D-1].r_idx[0];
            assign w_res_vld  = g_lvl[D-1].r_vld;
            assign w_res_last = g_lvl[D-1].r_last;
        end
    endgenerate

    logic [WIDTH-1:0] r_data;
    logic [IW-1:0]    r_idx;
    logic [CNT_W-1:0] r_pos;
    logic             r_valid;

    assign data_out  = r_data;
    assign idx_out   = r_idx;
    assign pos_out   = r_pos;
    assign valid_out = r_valid;

    generate
        if (HOLD_EN == 0) begin : g_out
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data  <= '0;
                    r_idx   <= '0;
                    r_pos   <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_res_vld;
                    r_pos   <= '0;
                    if (w_res_vld) begin
                        r_data <= w_res_val;
                        r_idx  <= w_res_idx;
                    end
                end
            end
        end else begin : g_out
            logic             r_have;
            logic [WIDTH-1:0] r_best_val;
            logic [IW-1:0]    r_best_idx;
            logic [CNT_W-1:0] r_best_pos;
            logic [CNT_W-1:0] r_cnt;
            logic [WIDTH-1:0] w_cmp_val;
            logic [IW-1:0]    w_cmp_idx;
            logic             w_take;
            logic [WIDTH-1:0] w_win_val;
            logic [IW-1:0]    w_win_idx;
            logic [CNT_W-1:0] w_win_pos;

            max_tree_node #(
                .WIDTH  (WIDTH),
                .SIGNED (SIGNED),
                .MODE   (MODE),
                .IW     (IW)
            ) u_hold_cmp (
                .i_a_val (r_best_val),
                .i_a_idx (r_best_idx),
                .i_b_val (w_res_val),
                .i_b_idx (w_res_idx),
                .o_val   (w_cmp_val),
                .o_idx   (w_cmp_idx)
            );

            // The node only picks the new result when strictly better, which
            // implies a different value, so a value change means "new wins".
            always_comb begin
                w_take    = !r_have || (w_cmp_val != r_best_val);
                w_win_val = w_take ? w_res_val : r_best_val;
                w_win_idx = w_take ? w_res_idx : r_best_idx;
                w_win_pos = w_take ? r_cnt     : r_best_pos;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data     <= '0;
                    r_idx      <= '0;
                    r_pos      <= '0;
                    r_valid    <= 1'b0;
                    r_have     <= 1'b0;
                    r_best_val <= '0;
                    r_best_idx <= '0;
                    r_best_pos <= '0;
                    r_cnt      <= '0;
                end else begin
                    r_valid <= 1'b0;
                    if (w_res_vld) begin
                        if (w_res_last) begin
                            r_valid <= 1'b1;
                            r_data  <= w_win_val;
                            r_idx   <= w_win_idx;
                            r_pos   <= w_win_pos;
                            r_have  <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_have     <= 1'b1;
                            r_best_val <= w_win_val;
                            r_best_idx <= w_win_idx;
                            r_best_pos <= w_win_pos;
                            r_cnt      <= (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_max_tree_pipe.sv
// Directed and scoreboarded checks of max_tree_pipe across several builds:
// plain max, signed min, peak hold, saturating position, 1 and 5 channels.
module tb_max_tree_pipe;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_we = 1'b0, b_we = 1'b0, c_we = 1'b0, c_last = 1'b0;
    logic        d_we = 1'b0, d_last = 1'b0, e_we = 1'b0, f_we = 1'b0;
    logic [31:0] a_data = '0, b_data = '0, c_data = '0, d_data = '0;
    logic [7:0]  e_data = '0;
    logic [39:0] f_data = '0;

    logic [7:0]  a_dout, b_dout, c_dout, d_dout, e_dout, f_dout;
    logic [1:0]  a_idx, b_idx, c_idx, d_idx;
    logic [0:0]  e_idx;
    logic [2:0]  f_idx;
    logic [15:0] a_pos, b_pos, c_pos, e_pos, f_pos;
    logic [1:0]  d_pos;
    logic        a_vld, b_vld, c_vld, d_vld, e_vld, f_vld;

    max_tree_pipe #(.WIDTH(8), .N_CH(4), .SIGNED(0), .MODE(0), .HOLD_EN(0), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .we(a_we), .last(1'b0), .data_in(a_data),
        .data_out(a_dout), .idx_out(a_idx), .pos_out(a_pos), .valid_out(a_vld));
    max_tree_pipe #(.WIDTH(8), .N_CH(4), .SIGNED(1), .MODE(1), .HOLD_EN(0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .we(b_we), .last(1'b0), .data_in(b_data),
        .data_out(b_dout), .idx_out(b_idx), .pos_out(b_pos), .valid_out(b_vld));
    max_tree_pipe #(.WIDTH(8), .N_CH(4), .SIGNED(0), .MODE(0), .HOLD_EN(1), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .we(c_we), .last(c_last), .data_in(c_data),
        .data_out(c_dout), .idx_out(c_idx), .pos_out(c_pos), .valid_out(c_vld));
    max_tree_pipe #(.WIDTH(8), .N_CH(4), .SIGNED(0), .MODE(0), .HOLD_EN(1), .CNT_W(2)) u_d (
        .clk(clk), .rst(rst), .we(d_we), .last(d_last), .data_in(d_data),
        .data_out(d_dout), .idx_out(d_idx), .pos_out(d_pos), .valid_out(d_vld));
    max_tree_pipe #(.WIDTH(8), .N_CH(1), .SIGNED(0), .MODE(0), .HOLD_EN(0), .CNT_W(16)) u_e (
        .clk(clk), .rst(rst), .we(e_we), .last(1'b0), .data_in(e_data),
        .data_out(e_dout), .idx_out(e_idx), .pos_out(e_pos), .valid_out(e_vld));
    max_tree_pipe #(.WIDTH(8), .N_CH(5), .SIGNED(0), .MODE(0), .HOLD_EN(0), .CNT_W(16)) u_f (
        .clk(clk), .rst(rst), .we(f_we), .last(1'b0), .data_in(f_data),
        .data_out(f_dout), .idx_out(f_idx), .pos_out(f_pos), .valid_out(f_vld));

    function automatic logic [31:0] pk4(input logic [7:0] c0, c1, c2, c3);
        return {c0, c1, c2, c3};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_we = 1'b1; a_data = pk4(1, 2, 3, 4);
        c_we = 1'b1; c_last = 1'b1; c_data = pk4(5, 5, 5, 5);
        f_we = 1'b1; f_data = '1;
        repeat (4) tick();
        checks++; if (a_vld !== 1'b0) begin failures++; $display("FAIL reset_a_vld: got %0d expected 0", a_vld); end
        checks++; if (a_dout !== 8'd0 || a_idx !== 2'd0 || a_pos !== 16'd0) begin failures++; $display("FAIL reset_a_out: got %0d/%0d/%0d expected 0/0/0", a_dout, a_idx, a_pos); end
        checks++; if (c_vld !== 1'b0 || c_dout !== 8'd0 || c_pos !== 16'd0) begin failures++; $display("FAIL reset_c_out: got %0d/%0d/%0d expected 0/0/0", c_vld, c_dout, c_pos); end
        checks++; if (f_vld !== 1'b0 || f_dout !== 8'd0 || f_idx !== 3'd0) begin failures++; $display("FAIL reset_f_out: got %0d/%0d/%0d expected 0/0/0", f_vld, f_dout, f_idx); end
        rst = 1'b0;
        a_we = 1'b0; a_data = '0; c_we = 1'b0; c_last = 1'b0; c_data = '0; f_we = 1'b0; f_data = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if ((a_vld | c_vld | f_vld) !== 1'b0) begin failures++; $display("FAIL reset_flush k=%0d: got a=%0d c=%0d f=%0d expected 0", k, a_vld, c_vld, f_vld); end
        end
        $display("test_reset: outputs cleared, samples under reset discarded");
    endtask

    task automatic test_latency();
        a_we = 1'b1; a_data = pk4(10, 200, 200, 5);
        tick();
        a_we = 1'b0; a_data = '0;
        checks++; if (a_vld !== 1'b0) begin failures++; $display("FAIL lat_edge1: got %0d expected 0", a_vld); end
        tick();
        checks++; if (a_vld !== 1'b0) begin failures++; $display("FAIL lat_edge2: got %0d expected 0", a_vld); end
        tick();
        checks++; if (a_vld !== 1'b1) begin failures++; $display("FAIL lat_edge3: got %0d expected 1", a_vld); end
        checks++; if (a_dout !== 8'd200 || a_idx !== 2'd1) begin failures++; $display("FAIL lat_value: got %0d idx %0d expected 200 idx 1", a_dout, a_idx); end
        tick();
        checks++; if (a_vld !== 1'b0 || a_dout !== 8'd200 || a_idx !== 2'd1) begin failures++; $display("FAIL lat_hold: got vld %0d %0d idx %0d expected 0 200 idx 1", a_vld, a_dout, a_idx); end
        $display("test_latency: {10,200,200,5} -> %0d idx %0d", a_dout, a_idx);
    endtask

    task automatic test_signed();
        a_we = 1'b1; b_we = 1'b1;
        a_data = pk4(8'h7F, 8'h80, 8'h01, 8'hFF); b_data = a_data;
        tick();
        a_we = 1'b0; b_we = 1'b0;
        tick(); tick();
        checks++; if (b_vld !== 1'b1 || b_dout !== 8'h80 || b_idx !== 2'd1) begin failures++; $display("FAIL signed_min: got vld %0d %h idx %0d expected 1 80 idx 1", b_vld, b_dout, b_idx); end
        checks++; if (a_vld !== 1'b1 || a_dout !== 8'hFF || a_idx !== 2'd3) begin failures++; $display("FAIL unsigned_max: got vld %0d %h idx %0d expected 1 ff idx 3", a_vld, a_dout, a_idx); end
        tick();
        $display("test_signed: signed min %h idx %0d, unsigned max %h idx %0d", b_dout, b_idx, a_dout, a_idx);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v [6];
        logic        w [6];
        logic [7:0]  ed [6];
        logic [1:0]  ei [6];
        logic [7:0]  hd;
        logic [1:0]  hi;
        logic        ev;
        int          s;
        v  = '{pk4(1, 2, 3, 4), pk4(9, 9, 9, 9), pk4(255, 255, 255, 255), pk4(5, 6, 6, 1), pk4(0, 0, 0, 0), pk4(3, 8, 2, 8)};
        w  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        ed = '{8'd4, 8'd9, 8'd0, 8'd6, 8'd0, 8'd8};
        ei = '{2'd3, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1};
        hd = 8'hFF; hi = 2'd3;
        for (int k = 0; k < 10; k++) begin
            a_we = (k < 6) ? w[k] : 1'b0;
            a_data = (k < 6) ? v[k] : '0;
            tick();
            s  = k - 2;
            ev = (s >= 0 && s < 6) ? w[s] : 1'b0;
            if (ev) begin hd = ed[s]; hi = ei[s]; end
            checks++; if (a_vld !== ev) begin failures++; $display("FAIL b2b_vld k=%0d: got %0d expected %0d", k, a_vld, ev); end
            checks++; if (a_dout !== hd || a_idx !== hi) begin failures++; $display("FAIL b2b_data k=%0d: got %0d idx %0d expected %0d idx %0d", k, a_dout, a_idx, hd, hi); end
        end
        $display("test_back_to_back: 5 samples with one bubble streamed");
    endtask

    task automatic test_hold();
        logic [31:0] v [4];
        int n;
        logic [7:0] gd; logic [1:0] gi; logic [15:0] gp;
        v = '{pk4(3, 0, 1, 2), pk4(0, 9, 0, 0), pk4(0, 0, 9, 0), pk4(2, 1, 0, 0)};
        n = 0; gd = '0; gi = '0; gp = '0;
        for (int k = 0; k < 12; k++) begin
            c_we = (k < 4); c_last = (k == 3); c_data = (k < 4) ? v[k] : '0;
            tick();
            if (c_vld) begin n++; gd = c_dout; gi = c_idx; gp = c_pos; end
        end
        checks++; if (n !== 1) begin failures++; $display("FAIL hold_strobes: got %0d expected 1", n); end
        checks++; if (gd !== 8'd9 || gi !== 2'd1 || gp !== 16'd1) begin failures++; $display("FAIL hold_result: got %0d idx %0d pos %0d expected 9 idx 1 pos 1", gd, gi, gp); end
        checks++; if (c_dout !== 8'd9 || c_pos !== 16'd1) begin failures++; $display("FAIL hold_stable: got %0d pos %0d expected 9 pos 1", c_dout, c_pos); end
        $display("test_hold: frame 3,9,9,2 -> %0d idx %0d pos %0d", gd, gi, gp);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            c_we = (k == 0); c_last = (k == 0); c_data = (k == 0) ? pk4(0, 0, 4, 0) : '0;
            tick();
            if (c_vld) begin n++; gd = c_dout; gi = c_idx; gp = c_pos; end
        end
        checks++; if (n !== 1 || gd !== 8'd4 || gi !== 2'd2 || gp !== 16'd0) begin failures++; $display("FAIL hold_single: got n %0d %0d idx %0d pos %0d expected n 1 4 idx 2 pos 0", n, gd, gi, gp); end
        $display("test_hold: one-sample frame -> %0d idx %0d pos %0d", gd, gi, gp);
    endtask

    task automatic test_frames_b2b();
        int n, f;
        logic [31:0] x;
        logic [7:0] xd; logic [1:0] xi; logic [15:0] xp;
        n = 0;
        for (int k = 0; k < 24; k++) begin
            if (k < 16) begin
                f = k / 2;
                x = '0;
                if (k % 2 == 0) x = pk4(8'(f), 0, 0, 0);
                else x[(3 - (f % 4)) * 8 +: 8] = (f % 2 == 0) ? 8'(f) : 8'(f + 1);
                c_we = 1'b1; c_last = (k % 2 == 1); c_data = x;
            end else begin
                c_we = 1'b0; c_last = 1'b0; c_data = '0;
            end
            tick();
            if (c_vld) begin
                xd = (n % 2 == 0) ? 8'(n) : 8'(n + 1);
                xi = (n % 2 == 0) ? 2'd0 : 2'(n % 4);
                xp = (n % 2 == 0) ? 16'd0 : 16'd1;
                checks++; if (c_dout !== xd || c_idx !== xi || c_pos !== xp) begin failures++; $display("FAIL frame%0d: got %0d idx %0d pos %0d expected %0d idx %0d pos %0d", n, c_dout, c_idx, c_pos, xd, xi, xp); end
                n++;
            end
        end
        checks++; if (n !== 8) begin failures++; $display("FAIL frames_count: got %0d expected 8", n); end
        $display("test_frames_b2b: %0d strobes for 8 two-sample frames", n);
    endtask

    task automatic test_saturate();
        logic [7:0] v [6];
        int n;
        logic [7:0] gd; logic [1:0] gi, gp;
        v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd5};
        n = 0; gd = '0; gi = '0; gp = '0;
        for (int k = 0; k < 14; k++) begin
            d_we = (k < 6); d_last = (k == 5); d_data = (k < 6) ? pk4(v[k], 0, 0, 0) : '0;
            tick();
            if (d_vld) begin n++; gd = d_dout; gi = d_idx; gp = d_pos; end
        end
        checks++; if (n !== 1 || gd !== 8'd9 || gi !== 2'd0 || gp !== 2'd3) begin failures++; $display("FAIL saturate: got n %0d %0d idx %0d pos %0d expected n 1 9 idx 0 pos 3", n, gd, gi, gp); end
        $display("test_saturate: 6-sample frame -> %0d pos %0d", gd, gp);
    endtask

    task automatic test_reset_midframe();
        int n;
        logic [7:0] gd; logic [1:0] gi; logic [15:0] gp;
        n = 0; gd = '0; gi = '0; gp = '0;
        for (int k = 0; k < 15; k++) begin
            rst = (k == 3);
            c_we = (k < 6);
            c_last = (k == 3) || (k == 5);
            case (k)
                0, 1, 2: c_data = pk4(50, 0, 0, 0);
                3:       c_data = pk4(99, 0, 0, 0);
                4:       c_data = pk4(5, 0, 0, 0);
                5:       c_data = pk4(0, 0, 7, 0);
                default: c_data = '0;
            endcase
            tick();
            if (c_vld) begin n++; gd = c_dout; gi = c_idx; gp = c_pos; end
        end
        rst = 1'b0;
        checks++; if (n !== 1) begin failures++; $display("FAIL midrst_strobes: got %0d expected 1", n); end
        checks++; if (gd !== 8'd7 || gi !== 2'd2 || gp !== 16'd1) begin failures++; $display("FAIL midrst_result: got %0d idx %0d pos %0d expected 7 idx 2 pos 1", gd, gi, gp); end
        $display("test_reset_midframe: new frame -> %0d idx %0d pos %0d", gd, gi, gp);
    endtask

    task automatic test_random();
        localparam int NS = 60;
        bit         e_ev [80];
        logic [7:0] e_ed [80];
        bit         f_ev [80];
        logic [7:0] f_ed [80];
        logic [2:0] f_ei [80];
        logic [7:0] vals [5];
        logic [7:0] best, e_hd, f_hd;
        logic [2:0] bi, f_hi;
        for (int i = 0; i < 80; i++) begin e_ev[i] = 0; f_ev[i] = 0; e_ed[i] = '0; f_ed[i] = '0; f_ei[i] = '0; end
        e_hd = '0; f_hd = '0; f_hi = '0;
        for (int k = 0; k < NS + 6; k++) begin
            if (k < NS) begin
                e_we = ($urandom_range(0, 9) < 7);
                e_data = 8'($urandom_range(0, 255));
                f_we = ($urandom_range(0, 9) < 7);
                for (int c = 0; c < 5; c++) begin
                    vals[c] = 8'($urandom_range(0, 3));
                    f_data[(4 - c) * 8 +: 8] = vals[c];
                end
                best = vals[0]; bi = 3'd0;
                for (int c = 1; c < 5; c++) if (vals[c] > best) begin best = vals[c]; bi = 3'(c); end
                if (e_we) begin e_ev[k] = 1; e_ed[k] = e_data; end
                if (f_we) begin f_ev[k + 3] = 1; f_ed[k + 3] = best; f_ei[k + 3] = bi; end
            end else begin
                e_we = 1'b0; f_we = 1'b0;
            end
            tick();
            if (e_ev[k]) e_hd = e_ed[k];
            if (f_ev[k]) begin f_hd = f_ed[k]; f_hi = f_ei[k]; end
            checks++; if (e_vld !== e_ev[k] || e_dout !== e_hd || e_idx !== 1'b0) begin failures++; $display("FAIL rand_n1 k=%0d: got vld %0d %0d idx %0d expected %0d %0d idx 0", k, e_vld, e_dout, e_idx, e_ev[k], e_hd); end
            checks++; if (f_vld !== f_ev[k] || f_dout !== f_hd || f_idx !== f_hi) begin failures++; $display("FAIL rand_n5 k=%0d: got vld %0d %0d idx %0d expected %0d %0d idx %0d", k, f_vld, f_dout, f_idx, f_ev[k], f_hd, f_hi); end
        end
        $display("test_random: %0d cycles on N_CH=1 and N_CH=5 builds", NS + 6);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_signed();
        test_back_to_back();
        test_hold();
        test_frames_b2b();
        test_saturate();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
